neurram_spi_sequencer: RTL and testbench

NEURRAM_SPI_SEQUENCER -- requirements
Module: neurram_spi_sequencer

---
 rtl/neurram_spi_pkg.sv | 44 ++++
 rtl/neurram_spi_sequencer_if.sv | 33 +++
 rtl/neurram_cmd_fifo.sv | 57 +++++
 rtl/neurram_spi_sequencer.sv | 136 +++++++++++++
 tb/tb_neurram_spi_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/neurram_spi_pkg.sv
// Shared definitions for the NeuRRAM SPI command sequencer and its SPI controller:
// state encoding, command word layout and field widths.
package neurram_spi_pkg;

    localparam int CFG_W    = 2;
    localparam int MULT_W   = 4;
    localparam int PIN_W    = 4;
    localparam int POUT_W   = 4;

    localparam int CFG_LSB  = 0;
    localparam int MULT_LSB = 2;
    localparam int PIN_LSB  = 6;
    localparam int POUT_LSB = 10;

    localparam int CMD_W    = CFG_W + MULT_W + PIN_W + POUT_W;
    localparam int COUNT_W  = 5;
    localparam int WAIT_W   = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_TRIG      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [POUT_W-1:0] pout;
        logic [PIN_W-1:0]  pin;
        logic [MULT_W-1:0] mult;
        logic [CFG_W-1:0]  cfg;
    } cmd_fields_t;

    function automatic cmd_fields_t unpack_cmd(input logic [CMD_W-1:0] word);
        cmd_fields_t f;
        f.cfg  = word[CFG_LSB  +: CFG_W];
        f.mult = word[MULT_LSB +: MULT_W];
        f.pin  = word[PIN_LSB  +: PIN_W];
        f.pout = word[POUT_LSB +: POUT_W];
        return f;
    endfunction

endpackage

// File: rtl/neurram_spi_sequencer_if.sv
// Host-side command/control bus and downstream SPI controller handshake of the sequencer.
interface neurram_spi_sequencer_if;
    import neurram_spi_pkg::*;

    logic [15:0]         cmd_din;
    logic                cmd_wr_en;
    logic                cmd_full;
    logic [COUNT_W-1:0]  cmd_count;
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic                timeout_err;
    logic                spi_trigger;
    logic [CFG_W-1:0]    spi_config;
    logic [MULT_W-1:0]   shift_multiplier;
    logic [PIN_W-1:0]    pipe_in_steps;
    logic [POUT_W-1:0]   pipe_out_steps;
    logic                spi_idle;

    modport master (
        output cmd_din, cmd_wr_en, start, abort, spi_idle,
        input  cmd_full, cmd_count, busy, done, timeout_err, spi_trigger,
               spi_config, shift_multiplier, pipe_in_steps, pipe_out_steps
    );

    modport slave (
        input  cmd_din, cmd_wr_en, start, abort, spi_idle,
        output cmd_full, cmd_count, busy, done, timeout_err, spi_trigger,
               spi_config, shift_multiplier, pipe_in_steps, pipe_out_steps
    );

endinterface

// File: rtl/neurram_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and single-cycle flush.
module neurram_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = wr_en && !full && !flush;
    assign pop_ok  = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/neurram_spi_sequencer.sv
// Drains a queue of SPI commands into the downstream controller, one trigger per command,
// with per-wait timeout supervision and abort.
module neurram_spi_sequencer
    import neurram_spi_pkg::*;
#(
    parameter int CMD_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                   clk,
    input  logic                   rst,
    neurram_spi_sequencer_if.slave bus
);
    seq_state_t         state_reg, state_next;
    logic               fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CMD_W-1:0]   fifo_rd_data;
    logic [COUNT_W-1:0] fifo_count;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_inc;
    logic               in_wait, wait_hit, timeout_hit;
    cmd_fields_t        fields_reg;
    logic               timeout_err_reg, done_reg;
    logic               busy_c, trig_c, done_set;
    logic               unused_reserved;

    assign unused_reserved = ^bus.cmd_din[15:14];

    neurram_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W),
        .CNT_W (COUNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.cmd_wr_en),
        .wr_data (bus.cmd_din[CMD_W-1:0]),
        .rd_en   (fifo_pop),
        .flush   (fifo_flush),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_wait      = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_IDLE);
    assign wait_cnt_inc = (&wait_cnt_reg) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);
    // Fires on the cycle whose increment makes the counter reach the limit.
    assign wait_hit     = in_wait && (wait_cnt_inc == WAIT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (fifo_empty)        state_next = ST_DONE;
                    else if (bus.spi_idle) state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop   = 1'b1;
                state_next = ST_TRIG;
            end
            ST_TRIG:      state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (wait_hit)           timeout_hit = 1'b1;
                else if (!bus.spi_idle) state_next  = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (wait_hit)          timeout_hit = 1'b1;
                else if (bus.spi_idle) state_next  = fifo_empty ? ST_DONE : ST_LOAD;
            end
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
        if (timeout_hit) begin
            fifo_flush = 1'b1;
            state_next = ST_IDLE;
        end
        // Abort overrides everything, including a same-cycle start or timeout.
        if (bus.abort) begin
            fifo_flush  = 1'b1;
            fifo_pop    = 1'b0;
            timeout_hit = 1'b0;
            state_next  = ST_IDLE;
        end
    end

    always_comb begin
        busy_c   = (state_reg != ST_IDLE);
        trig_c   = (state_reg == ST_TRIG) && !bus.abort;
        done_set = (state_reg == ST_DONE) && !bus.abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if ((state_next != state_reg) &&
                     ((state_next == ST_WAIT_BUSY) || (state_next == ST_WAIT_IDLE))) begin
            wait_cnt_reg <= '0;
        end else if (in_wait) begin
            wait_cnt_reg <= wait_cnt_inc;
        end
    end

    // done is registered, so it appears the cycle after DONE (two cycles after an empty start).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            fields_reg      <= '0;
        end else begin
            done_reg <= done_set;
            if (timeout_hit)                           timeout_err_reg <= 1'b1;
            else if (state_reg == ST_IDLE && bus.start) timeout_err_reg <= 1'b0;
            if (state_reg == ST_LOAD && !bus.abort)    fields_reg <= unpack_cmd(fifo_rd_data);
        end
    end

    assign bus.cmd_full         = fifo_full;
    assign bus.cmd_count        = fifo_count;
    assign bus.busy             = busy_c;
    assign bus.done             = done_reg;
    assign bus.timeout_err      = timeout_err_reg;
    assign bus.spi_trigger      = trig_c;
    assign bus.spi_config       = fields_reg.cfg;
    assign bus.shift_multiplier = fields_reg.mult;
    assign bus.pipe_in_steps    = fields_reg.pin;
    assign bus.pipe_out_steps   = fields_reg.pout;

endmodule

// File: tb/tb_neurram_spi_sequencer.sv
// Directed self-checking bench for neurram_spi_sequencer (CMD_DEPTH=8, TIMEOUT_CYCLES=100).
module tb_neurram_spi_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    neurram_spi_sequencer_if bus();

    neurram_spi_sequencer #(
        .CMD_DEPTH      (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int trig_cnt = 0;
    int done_cnt = 0;

    // Downstream controller model: goes busy for 10 cycles after each trigger.
    int ds_cnt        = 0;
    bit ds_ignore     = 1'b0;
    bit ds_force_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst)                               ds_cnt <= 0;
        else if (bus.spi_trigger && !ds_ignore) ds_cnt <= 10;
        else if (ds_cnt != 0)                  ds_cnt <= ds_cnt - 1;
    end

    assign bus.spi_idle = !ds_force_busy && (ds_cnt == 0);

    always @(negedge clk) begin
        if (bus.spi_trigger === 1'b1) trig_cnt++;
        if (bus.done === 1'b1)        done_cnt++;
    end

    function automatic logic [13:0] fields();
        return {bus.pipe_out_steps, bus.pipe_in_steps, bus.shift_multiplier, bus.spi_config};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic push(input logic [15:0] w);
        bus.cmd_din   = w;
        bus.cmd_wr_en = 1'b1;
        @(negedge clk);
        bus.cmd_wr_en = 1'b0;
        $display("push 0x%04h -> count %0d full %0d", w, bus.cmd_count, bus.cmd_full);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_trig(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = bus.spi_trigger;
        end
        check_val(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_not_busy(input int budget, input string tag);
        bit idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        check_val(tag, 32'(idle), 32'd1);
    endtask

    task automatic check_all_reset(input string pfx);
        check_val({pfx, "_busy"},   32'(bus.busy),        32'd0);
        check_val({pfx, "_done"},   32'(bus.done),        32'd0);
        check_val({pfx, "_trig"},   32'(bus.spi_trigger), 32'd0);
        check_val({pfx, "_tmo"},    32'(bus.timeout_err), 32'd0);
        check_val({pfx, "_count"},  32'(bus.cmd_count),   32'd0);
        check_val({pfx, "_full"},   32'(bus.cmd_full),    32'd0);
        check_val({pfx, "_fields"}, 32'(fields()),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, s_cyc;
        logic [13:0] exp_f [3];
        logic [13:0] got_f [3];
        exp_f[0] = 14'h0006;
        exp_f[1] = 14'h0405;
        exp_f[2] = 14'h0843;

        bus.cmd_din   = '0;
        bus.cmd_wr_en = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;

        repeat (3) @(negedge clk);
        check_all_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: three commands, 10-cycle downstream busy each.
        push(16'h0006);
        push(16'h0405);
        push(16'h0843);
        check_val("s1_count_loaded", 32'(bus.cmd_count), 32'd3);
        t0 = trig_cnt;
        d0 = done_cnt;
        s_cyc = cyc;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_trig(40, $sformatf("s1_trig%0d_seen", k));
            if (k == 0) check_val("s1_latency", 32'(cyc - s_cyc), 32'd2);
            got_f[k] = fields();
        end
        for (int k = 0; k < 3; k++)
            check_val($sformatf("s1_fields%0d", k), 32'(got_f[k]), 32'(exp_f[k]));
        wait_not_busy(60, "s1_finished");
        repeat (3) @(negedge clk);
        check_val("s1_trig_total", 32'(trig_cnt - t0), 32'd3);
        check_val("s1_done_total", 32'(done_cnt - d0), 32'd1);
        check_val("s1_count_end",  32'(bus.cmd_count), 32'd0);
        check_val("s1_fields_held", 32'(fields()), 32'h0843);

        // Scenario 2: overfill the queue, then abort+start together.
        for (int i = 0; i < 9; i++) begin
            push(16'h1000 + 16'(i));
            if (i == 7) begin
                check_val("s2_full_after8",  32'(bus.cmd_full),  32'd1);
                check_val("s2_count_after8", 32'(bus.cmd_count), 32'd8);
            end
        end
        check_val("s2_count_after9", 32'(bus.cmd_count), 32'd8);
        check_val("s2_full_after9",  32'(bus.cmd_full),  32'd1);
        t0 = trig_cnt;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_val("s2_abort_start_busy",  32'(bus.busy),      32'd0);
        check_val("s2_abort_start_count", 32'(bus.cmd_count), 32'd0);
        repeat (3) @(negedge clk);
        check_val("s2_abort_start_trig", 32'(trig_cnt - t0), 32'd0);

        // Scenario 3: downstream never goes busy -> timeout in WAIT_BUSY.
        ds_ignore = 1'b1;
        push(16'h0011);
        push(16'h0022);
        d0 = done_cnt;
        pulse_start();
        wait_trig(5, "s3_trig_seen");
        repeat (100) @(negedge clk);
        check_val("s3_tmo_before", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        check_val("s3_tmo_set",  32'(bus.timeout_err), 32'd1);
        check_val("s3_busy",     32'(bus.busy),        32'd0);
        check_val("s3_count",    32'(bus.cmd_count),   32'd0);
        repeat (3) @(negedge clk);
        check_val("s3_tmo_sticky", 32'(bus.timeout_err), 32'd1);
        check_val("s3_no_done",    32'(done_cnt - d0),   32'd0);
        ds_ignore = 1'b0;

        // Scenario 5: empty start, then start while downstream reports busy.
        t0 = trig_cnt;
        pulse_start();
        check_val("s5_done_c1",    32'(bus.done),        32'd0);
        check_val("s5_tmo_clear",  32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        check_val("s5_done_c2",    32'(bus.done),        32'd1);
        @(negedge clk);
        check_val("s5_done_c3",    32'(bus.done),        32'd0);
        check_val("s5_no_trig",    32'(trig_cnt - t0),   32'd0);
        push(16'h0123);
        ds_force_busy = 1'b1;
        pulse_start();
        check_val("s5_busy_ignored_c1", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_val("s5_busy_ignored_c2", 32'(bus.busy),      32'd0);
        check_val("s5_count_kept",      32'(bus.cmd_count), 32'd1);
        check_val("s5_trig_ignored",    32'(trig_cnt - t0), 32'd0);
        ds_force_busy = 1'b0;
        @(negedge clk);

        // Scenario 4: abort during WAIT_IDLE of the first of four commands.
        push(16'h0101);
        push(16'h0202);
        push(16'h0303);
        check_val("s4_count_loaded", 32'(bus.cmd_count), 32'd4);
        t0 = trig_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_trig(5, "s4_trig_seen");
        check_val("s4_first_fields", 32'(fields()), 32'h0123);
        repeat (2) @(negedge clk);
        check_val("s4_count_before_abort", 32'(bus.cmd_count), 32'd3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("s4_idle_after_abort", 32'(bus.busy),      32'd0);
        check_val("s4_count_flushed",    32'(bus.cmd_count), 32'd0);
        repeat (30) @(negedge clk);
        check_val("s4_single_trig", 32'(trig_cnt - t0), 32'd1);
        check_val("s4_no_done",     32'(done_cnt - d0), 32'd0);

        // Scenario 6: append during WAIT_IDLE, then async reset mid-transfer.
        push(16'h1234);
        pulse_start();
        wait_trig(5, "s6_trig_a_seen");
        check_val("s6_fields_a", 32'(fields()), 32'h1234);
        repeat (2) @(negedge clk);
        push(16'hC3C5);
        check_val("s6_count_appended", 32'(bus.cmd_count), 32'd1);
        wait_trig(40, "s6_trig_b_seen");
        check_val("s6_fields_b", 32'(fields()), 32'h03C5);
        repeat (2) @(negedge clk);
        check_val("s6_busy_before_rst", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_reset("s6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("s6_busy_after_rst", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
